// File: rtl/jtframe_prog_seq.sv
// ROM download sequencer: ioctl byte stream to SDRAM programming port.
// Bytes are bank-mapped, queued, and issued as masked 16-bit writes.
module jtframe_prog_seq #(
  parameter int          SDRAMW    = 22,
  parameter logic [24:0] BA1_START = 25'h10_0000,
  parameter logic [24:0] BA2_START = 25'h20_0000,
  parameter logic [24:0] BA3_START = 25'h30_0000,
  parameter int          DEPTH     = 4
) (
  input  logic              clk_rom,
  input  logic              rst,
  input  logic              downloading,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_data,
  input  logic              ioctl_wr,
  output logic [SDRAMW-1:0] prog_addr,
  output logic [1:0]        prog_ba,
  output logic [15:0]       prog_din,
  output logic [1:0]        prog_din_m,
  output logic              prog_we,
  input  logic              prog_rdy,
  output logic              dwnld_busy,
  output logic              overflow
);

  // The entry being written stays at the head until acknowledged, so
  // one slot beyond DEPTH holds the write in flight.
  localparam int SLOTS = DEPTH + 1;
  localparam int PW    = $clog2(SLOTS);
  localparam int CW    = $clog2(SLOTS + 1);
  localparam int EW    = 2 + SDRAMW + 8 + 1;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t state_q, state_d;

  logic [EW-1:0]     mem [SLOTS];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     cnt;
  logic [24:0]       off;
  logic [1:0]        ba;
  logic [EW-1:0]     entry, head;
  logic              full, push, pop, drop, dl_q, rise;
  logic [SDRAMW-1:0] addr_d;
  logic [1:0]        ba_d, m_d;
  logic [15:0]       din_d;
  logic              we_d;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH)) ? '0 : p + 1'b1;
  endfunction

  // Bank map of the incoming byte address
  always_comb begin
    ba  = 2'd3;
    off = ioctl_addr - BA3_START;
    if (ioctl_addr < BA1_START) begin
      ba  = 2'd0;
      off = ioctl_addr;
    end else if (ioctl_addr < BA2_START) begin
      ba  = 2'd1;
      off = ioctl_addr - BA1_START;
    end else if (ioctl_addr < BA3_START) begin
      ba  = 2'd2;
      off = ioctl_addr - BA2_START;
    end
  end

  assign entry = {ba, SDRAMW'(off >> 1), ioctl_data, ioctl_addr[0]};
  assign head  = mem[rd_ptr];
  assign full  = cnt == CW'(SLOTS);
  assign pop   = (state_q == WRITE) && prog_rdy;
  assign push  = ioctl_wr && downloading && (!full || pop);
  assign drop  = ioctl_wr && downloading && full && !pop;
  assign rise  = downloading && !dl_q;

  // FIFO storage, not reset: validity is tracked by cnt
  always_ff @(posedge clk_rom) begin
    if (push) mem[wr_ptr] <= entry;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= inc(wr_ptr);
      if (pop)  rd_ptr <= inc(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Next state and next output register values
  always_comb begin
    state_d = state_q;
    we_d    = prog_we;
    addr_d  = prog_addr;
    ba_d    = prog_ba;
    din_d   = prog_din;
    m_d     = prog_din_m;
    unique case (state_q)
      IDLE: begin
        if (cnt != '0) begin
          ba_d    = head[EW-1 -: 2];
          addr_d  = head[EW-3 -: SDRAMW];
          din_d   = {head[8:1], head[8:1]};
          m_d     = head[0] ? 2'b01 : 2'b10;
          we_d    = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (prog_rdy) begin
          we_d    = 1'b0;
          m_d     = 2'b11;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and programming port registers
  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      prog_we    <= 1'b0;
      prog_addr  <= '0;
      prog_ba    <= '0;
      prog_din   <= '0;
      prog_din_m <= 2'b11;
    end else begin
      state_q    <= state_d;
      prog_we    <= we_d;
      prog_addr  <= addr_d;
      prog_ba    <= ba_d;
      prog_din   <= din_d;
      prog_din_m <= m_d;
    end
  end

  // Busy flag and sticky overflow, cleared when a download starts
  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) begin
      dl_q       <= 1'b0;
      dwnld_busy <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      dl_q       <= downloading;
      dwnld_busy <= downloading || (cnt != '0) || (state_q == WRITE);
      if (drop)      overflow <= 1'b1;
      else if (rise) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtframe_prog_seq.sv
// Directed bench for jtframe_prog_seq.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_jtframe_prog_seq;

  logic        clk_rom = 1'b0;
  logic        rst = 1'b1;
  logic        downloading = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_data = '0;
  logic        ioctl_wr = 1'b0;
  logic [21:0] prog_addr;
  logic [1:0]  prog_ba;
  logic [15:0] prog_din;
  logic [1:0]  prog_din_m;
  logic        prog_we;
  logic        prog_rdy = 1'b0;
  logic        dwnld_busy;
  logic        overflow;

  int n_chk = 0;
  int n_err = 0;

  jtframe_prog_seq dut (
    .clk_rom     (clk_rom),
    .rst         (rst),
    .downloading (downloading),
    .ioctl_addr  (ioctl_addr),
    .ioctl_data  (ioctl_data),
    .ioctl_wr    (ioctl_wr),
    .prog_addr   (prog_addr),
    .prog_ba     (prog_ba),
    .prog_din    (prog_din),
    .prog_din_m  (prog_din_m),
    .prog_we     (prog_we),
    .prog_rdy    (prog_rdy),
    .dwnld_busy  (dwnld_busy),
    .overflow    (overflow)
  );

  always #5 clk_rom = ~clk_rom;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    @(negedge clk_rom);
    ioctl_wr   = 1'b0;
  endtask

  task automatic ack();
    prog_rdy = 1'b1;
    @(negedge clk_rom);
    prog_rdy = 1'b0;
  endtask

  task automatic wait_we(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (prog_we) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_rom);
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk_rom);
    chk("rst_we", 32'(prog_we), 0);
    chk("rst_m", 32'(prog_din_m), 32'h3);
    chk("rst_addr", 32'(prog_addr), 0);
    chk("rst_busy", 32'(dwnld_busy), 0);
    chk("rst_ovf", 32'(overflow), 0);
    rst = 1'b0;
    downloading = 1'b1;
    @(negedge clk_rom);
    @(negedge clk_rom);
    chk("busy_dl", 32'(dwnld_busy), 1);

    // single byte, held until ack
    wr_byte(25'h3, 8'hA5);
    chk("lat_we0", 32'(prog_we), 0);
    @(negedge clk_rom);
    chk("one_we", 32'(prog_we), 1);
    chk("one_ba", 32'(prog_ba), 0);
    chk("one_addr", 32'(prog_addr), 1);
    chk("one_din", 32'(prog_din), 32'hA5A5);
    chk("one_m", 32'(prog_din_m), 32'h1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_rom);
      chk("one_hold", 32'(prog_we), 1);
    end
    ack();
    chk("one_we_off", 32'(prog_we), 0);
    chk("one_m_off", 32'(prog_din_m), 32'h3);
    chk("one_din_keep", 32'(prog_din), 32'hA5A5);
    chk("one_addr_keep", 32'(prog_addr), 1);
    @(negedge clk_rom);
    chk("one_no_more", 32'(prog_we), 0);

    // bank map
    wr_byte(25'h10_0004, 8'h11);
    @(negedge clk_rom);
    chk("b1_ba", 32'(prog_ba), 1);
    chk("b1_addr", 32'(prog_addr), 2);
    chk("b1_m", 32'(prog_din_m), 32'h2);
    chk("b1_din", 32'(prog_din), 32'h1111);
    ack();
    wr_byte(25'h2F_FFFF, 8'h22);
    @(negedge clk_rom);
    chk("b2_ba", 32'(prog_ba), 2);
    chk("b2_addr", 32'(prog_addr), 32'h7FFFF);
    chk("b2_m", 32'(prog_din_m), 32'h1);
    ack();
    wr_byte(25'h30_0000, 8'h33);
    @(negedge clk_rom);
    chk("b3_ba", 32'(prog_ba), 3);
    chk("b3_addr", 32'(prog_addr), 0);
    chk("b3_m", 32'(prog_din_m), 32'h2);
    ack();

    // FIFO full: six bytes, five accepted
    for (int k = 0; k < 6; k++) begin
      ioctl_addr = 25'(k * 2);
      ioctl_data = 8'(8'h10 + k);
      ioctl_wr   = 1'b1;
      @(negedge clk_rom);
      if (k == 4) chk("full_ovf0", 32'(overflow), 0);
    end
    ioctl_wr = 1'b0;
    chk("full_ovf1", 32'(overflow), 1);
    for (int k = 0; k < 5; k++) begin
      wait_we("full_we");
      chk("full_din", 32'(prog_din), 32'((8'h10 + k) * 257));
      chk("full_addr", 32'(prog_addr), 32'(k));
      ack();
    end
    @(negedge clk_rom);
    chk("full_no6", 32'(prog_we), 0);

    // overflow is sticky, cleared on new download
    downloading = 1'b0;
    @(negedge clk_rom);
    @(negedge clk_rom);
    chk("ovf_sticky", 32'(overflow), 1);
    downloading = 1'b1;
    @(negedge clk_rom);
    chk("ovf_clr", 32'(overflow), 0);

    // full with simultaneous pop accepts the byte
    for (int k = 0; k < 5; k++) begin
      ioctl_addr = 25'(k * 2);
      ioctl_data = 8'(8'h20 + k);
      ioctl_wr   = 1'b1;
      @(negedge clk_rom);
    end
    ioctl_addr = 25'd10;
    ioctl_data = 8'h25;
    prog_rdy   = 1'b1;
    @(negedge clk_rom);
    ioctl_wr = 1'b0;
    prog_rdy = 1'b0;
    chk("fp_ovf", 32'(overflow), 0);
    for (int k = 1; k < 6; k++) begin
      wait_we("fp_we");
      chk("fp_din", 32'(prog_din), 32'((8'h20 + k) * 257));
      ack();
    end
    @(negedge clk_rom);
    chk("fp_no_more", 32'(prog_we), 0);

    // drain after downloading falls
    for (int k = 0; k < 3; k++) begin
      ioctl_addr = 25'(k);
      ioctl_data = 8'(8'h30 + k);
      ioctl_wr   = 1'b1;
      @(negedge clk_rom);
    end
    ioctl_wr = 1'b0;
    downloading = 1'b0;
    @(negedge clk_rom);
    @(negedge clk_rom);
    for (int k = 0; k < 3; k++) begin
      wait_we("dr_we");
      chk("dr_busy", 32'(dwnld_busy), 1);
      chk("dr_din", 32'(prog_din), 32'((8'h30 + k) * 257));
      ack();
    end
    chk("dr_busy_last", 32'(dwnld_busy), 1);
    @(negedge clk_rom);
    chk("dr_busy_off", 32'(dwnld_busy), 0);

    // reset in the middle of a write
    downloading = 1'b1;
    @(negedge clk_rom);
    wr_byte(25'h8, 8'h77);
    @(negedge clk_rom);
    chk("mr_we_pre", 32'(prog_we), 1);
    #2 rst = 1'b1;
    #1;
    chk("mr_we", 32'(prog_we), 0);
    chk("mr_busy", 32'(dwnld_busy), 0);
    chk("mr_m", 32'(prog_din_m), 32'h3);
    @(negedge clk_rom);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_rom);
      chk("mr_no_we", 32'(prog_we), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/jtframe_prog_seq.md
Name: jtframe_prog_seq

Overview:
- Sequences ROM download bytes from the SPI loader into the SDRAM controller's programming port.
- Sits between the ioctl byte stream and the prog_* inputs of the SDRAM controller.
- Maps each byte address to one of four banks and buffers bytes in a small FIFO, because ioctl_wr cannot be stalled.
- Issues one masked 16-bit write per byte and reports busy until everything has drained.

Parameters:
- SDRAMW, 22, word address width of prog_addr.
- BA1_START, 25'h10_0000, first byte address mapped to bank 1.
- BA2_START, 25'h20_0000, first byte address mapped to bank 2.
- BA3_START, 25'h30_0000, first byte address mapped to bank 3.
- DEPTH, 4, FIFO entries; must be a power of two, 2..16.

Ports:
- clk_rom  in  1  system/SDRAM clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- downloading  in  1  ROM download in progress, from the loader.
- ioctl_addr  in  25  byte address of the incoming byte.
- ioctl_data  in  8  incoming byte.
- ioctl_wr  in  1  one-cycle strobe, byte valid.
- prog_addr  out  SDRAMW  word address within the bank.
- prog_ba  out  2  target bank.
- prog_din  out  16  write data.
- prog_din_m  out  2  byte mask, active high = byte NOT written.
- prog_we  out  1  write request, held until acknowledged.
- prog_rdy  in  1  one-cycle acknowledge from the SDRAM controller.
- dwnld_busy  out  1  download or drain still in progress.
- overflow  out  1  sticky: a byte was dropped.

Behaviour:
- Reset (asynchronous) clears the following immediately, mid-transfer included:
  - prog_we=0, prog_addr=0, prog_ba=0, prog_din=0, prog_din_m=2'b11;
  - FIFO empty, FSM in IDLE, overflow=0, dwnld_busy=0.
  - No pending write is completed.
- Bank map, with a = ioctl_addr:
  - a<BA1_START: bank 0, off=a.
  - a<BA2_START: bank 1, off=a-BA1_START.
  - a<BA3_START: bank 2, off=a-BA2_START.
  - otherwise: bank 3, off=a-BA3_START.
  - Word address = off[SDRAMW:1]; higher bits are truncated.
- Entry format is {ba, word addr, byte, odd=a[0]}, computed at push time.
- FIFO push:
  - On ioctl_wr when count<DEPTH, or when a pop occurs in the same cycle (full with simultaneous pop is accepted).
  - Otherwise the byte is dropped and overflow is set.
  - ioctl_wr is ignored while downloading=0.
- FSM has two states.
  - IDLE:
    - If the FIFO is non-empty, load the head into the output registers, set prog_we=1 and go to WRITE.
    - prog_din = {byte,byte}.
    - prog_din_m = odd ? 2'b01 : 2'b10.
  - WRITE:
    - Hold prog_we and all outputs stable until prog_rdy=1.
    - In the cycle prog_rdy=1: pop the head; on the next edge prog_we=0, prog_din_m=2'b11, return to IDLE.
    - prog_addr, prog_ba and prog_din keep their last values.
- Timing:
  - Latency with an empty FIFO: ioctl_wr sampled at edge E0 gives prog_we=1 after edge E1.
  - Back-to-back entries have a minimum 1-cycle gap with prog_we=0.
  - A prog_rdy in IDLE is ignored.
- dwnld_busy = downloading | FIFO non-empty | state==WRITE, registered. It falls one cycle after the last prog_rdy once downloading=0.
- overflow:
  - Sticky; cleared on the rising edge of downloading.
  - If a drop happens in the same cycle as that rising edge, the drop wins and overflow is set.
- Falling edge of downloading does not flush; the FIFO drains fully.

Test Plan:
- Reset mid-WRITE: assert rst while prog_we=1 -> prog_we=0 and dwnld_busy=0 within the same cycle; after release, no write is issued.
- Single byte: addr 25'h0000_03, data 8'hA5 -> prog_ba=0, prog_addr=1, prog_din=16'hA5A5, prog_din_m=2'b01, prog_we=1 one cycle after ioctl_wr; held 5 cycles until prog_rdy; then 0.
- Bank map: addr 25'h10_0004 -> ba=1, addr=2, mask 2'b10; addr 25'h2F_FFFF -> ba=2, addr=22'h7_FFFF; addr 25'h30_0000 -> ba=3, addr=0.
- FIFO full with prog_rdy withheld, DEPTH=4:
  - 6 consecutive ioctl_wr -> 5 accepted (1 issued + 4 buffered), overflow=1 after the 6th.
  - On release, exactly 5 writes come out in order.
- Full + simultaneous pop: FIFO full, ioctl_wr coincides with prog_rdy -> byte accepted, overflow stays 0.
- Drain: downloading falls with 3 entries queued -> dwnld_busy stays 1 until one cycle after the 3rd prog_rdy.
- Overflow clear: a new rising edge of downloading clears overflow.
